// File: rtl/imem_responder_pkg.sv
// Shared widths and encodings for the instruction/data memory responder.
package imem_responder_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } req_kind_t;
endpackage

// File: rtl/imem_responder_mem_array_2p.sv
// Single-clock memory: one synchronous write port, one asynchronous read port.
module mem_array_2p #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// Services instruction fetches, data loads and data stores against internal
// arrays; reads respond after LATENCY cycles, stores complete in IDLE.
module imem_responder #(
    parameter int ADDR_W  = imem_responder_pkg::ADDR_W,
    parameter int INSTR_W = imem_responder_pkg::INSTR_W,
    parameter int DATA_W  = imem_responder_pkg::DATA_W,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_fetch_pulse,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic               en_ldr,
    input  logic               en_str,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic [DATA_W-1:0]  str_data,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               en1,
    output logic [INSTR_W-1:0] instr,
    output logic               ldr_valid,
    output logic [DATA_W-1:0]  ldr_data,
    output logic               str_ack,
    output logic               busy,
    output logic               req_drop
);
    import imem_responder_pkg::*;

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t              state;
    req_kind_t           rd_kind;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic                ldr_q, str_q;
    logic                ldr_rise, str_rise, any_req, idle;
    logic                acc_fetch, acc_str, acc_ldr, drop, iwe, dwe;
    logic [ADDR_W-1:0]   raddr;
    logic [INSTR_W-1:0]  irdata;
    logic [DATA_W-1:0]   drdata;

    always_comb begin
        ldr_rise  = en_ldr & ~ldr_q;
        str_rise  = en_str & ~str_q;
        any_req   = en_fetch_pulse | ldr_rise | str_rise;
        idle      = (state == IDLE);
        acc_fetch = idle & en_fetch_pulse;
        acc_str   = idle & ~en_fetch_pulse & str_rise;
        acc_ldr   = idle & ~en_fetch_pulse & ~str_rise & ldr_rise;
        // Losers of the priority race and anything arriving while busy are dropped.
        drop      = idle ? ($countones({en_fetch_pulse, str_rise, ldr_rise}) > 1) : any_req;
        drop      = drop | (prog_we & ~(idle & ~any_req));
        iwe       = ~rst & prog_we & idle & ~any_req;
        dwe       = ~rst & acc_str;
        // In IDLE the read port looks at the incoming address so LATENCY=1 can respond at once.
        raddr     = idle ? (en_fetch_pulse ? pc_addr : data_addr) : rd_addr;
    end

    assign busy = (state != IDLE);

    mem_array_2p #(.AW(ADDR_W), .DW(INSTR_W)) u_imem (
        .clk(clk), .we(iwe), .waddr(prog_addr), .wdata(prog_data),
        .raddr(raddr), .rdata(irdata)
    );

    mem_array_2p #(.AW(ADDR_W), .DW(DATA_W)) u_dmem (
        .clk(clk), .we(dwe), .waddr(data_addr), .wdata(str_data),
        .raddr(raddr), .rdata(drdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ldr_q     <= 1'b0;
            str_q     <= 1'b0;
            en1       <= 1'b0;
            ldr_valid <= 1'b0;
            str_ack   <= 1'b0;
            req_drop  <= 1'b0;
            instr     <= '0;
            ldr_data  <= '0;
            rd_addr   <= '0;
            rd_kind   <= FETCH;
        end else begin
            ldr_q     <= en_ldr;
            str_q     <= en_str;
            en1       <= 1'b0;
            ldr_valid <= 1'b0;
            str_ack   <= acc_str;
            req_drop  <= drop;
            case (state)
                IDLE: begin
                    if (acc_fetch || acc_ldr) begin
                        rd_addr <= raddr;
                        rd_kind <= acc_fetch ? FETCH : LOAD;
                        cnt     <= CNT_INIT;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state     <= RESP;
                            en1       <= acc_fetch;
                            ldr_valid <= acc_ldr;
                            if (acc_fetch) instr <= irdata;
                            else           ldr_data <= drdata;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        en1       <= (rd_kind == FETCH);
                        ldr_valid <= (rd_kind == LOAD);
                        if (rd_kind == FETCH) instr <= irdata;
                        else                  ldr_data <= drdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed scenarios plus a randomized run against a cycle-level transaction model.
module tb_imem_responder;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst, fp, en_ldr, en_str, pwe;
    logic [7:0]  pc, daddr, sdata, paddr;
    logic [15:0] pdata;
    logic        en1, ldr_valid, str_ack, busy, req_drop;
    logic [15:0] instr;
    logic [7:0]  ldr_data;

    logic        fp1, pwe1;
    logic [7:0]  pc1, paddr1;
    logic [15:0] pdata1;
    logic        en1_1, ldr_valid_1, str_ack_1, busy_1, req_drop_1;
    logic [15:0] instr_1;
    logic [7:0]  ldr_data_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(8), .INSTR_W(16), .DATA_W(8), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .en_fetch_pulse(fp), .pc_addr(pc),
        .en_ldr(en_ldr), .en_str(en_str), .data_addr(daddr), .str_data(sdata),
        .prog_we(pwe), .prog_addr(paddr), .prog_data(pdata),
        .en1(en1), .instr(instr), .ldr_valid(ldr_valid), .ldr_data(ldr_data),
        .str_ack(str_ack), .busy(busy), .req_drop(req_drop)
    );

    imem_responder #(.ADDR_W(8), .INSTR_W(16), .DATA_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .en_fetch_pulse(fp1), .pc_addr(pc1),
        .en_ldr(1'b0), .en_str(1'b0), .data_addr(8'h00), .str_data(8'h00),
        .prog_we(pwe1), .prog_addr(paddr1), .prog_data(pdata1),
        .en1(en1_1), .instr(instr_1), .ldr_valid(ldr_valid_1), .ldr_data(ldr_data_1),
        .str_ack(str_ack_1), .busy(busy_1), .req_drop(req_drop_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fp = 1'b1; en_ldr = 1'b1; en_str = 1'b1; pwe = 1'b1;
        fp1 = 1'b1; pwe1 = 1'b1;
        tick(); tick();
        n_tests++;
        if ({en1, ldr_valid, str_ack, req_drop, busy, instr, ldr_data} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {en1, ldr_valid, str_ack, req_drop, busy, instr, ldr_data});
        end
        n_tests++;
        if ({en1_1, busy_1, req_drop_1, instr_1} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got %h expected 0", {en1_1, busy_1, req_drop_1, instr_1});
        end
        rst = 1'b0; fp = 1'b0; en_ldr = 1'b0; en_str = 1'b0; pwe = 1'b0;
        fp1 = 1'b0; pwe1 = 1'b0;
        tick();
        n_tests++;
        if ({req_drop, busy, str_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %b expected 000", {req_drop, busy, str_ack});
        end
    endtask

    task automatic test_fetch();
        pwe = 1'b1; paddr = 8'd5; pdata = 16'hA3C1;
        pwe1 = 1'b1; paddr1 = 8'd5; pdata1 = 16'hA3C1;
        tick();
        pwe = 1'b1; paddr = 8'd6; pdata = 16'h1111; pwe1 = 1'b0;
        tick();
        pwe = 1'b0;
        fp = 1'b1; pc = 8'd5;
        tick();
        fp = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if ({en1, busy} !== {i == 2, i <= 2}) begin
                n_fail++;
                $display("FAIL fetch_timing cyc+%0d: en1,busy=%b expected %b", i, {en1, busy}, {i == 2, i <= 2});
            end
            if (i >= 2) begin
                n_tests++;
                if (instr !== 16'hA3C1) begin
                    n_fail++;
                    $display("FAIL fetch_instr cyc+%0d: got %h expected a3c1", i, instr);
                end
            end
            tick();
        end
    endtask

    task automatic test_store_load();
        int acks = 0, busies = 0;
        en_str = 1'b1; daddr = 8'h20; sdata = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) en_str = 1'b0;
            tick();
            acks += int'(str_ack);
            busies += int'(busy);
        end
        n_tests++;
        if (acks != 1 || busies != 0) begin
            n_fail++;
            $display("FAIL store_ack_count: acks=%0d busy_cycles=%0d expected 1 and 0", acks, busies);
        end
        en_ldr = 1'b1; daddr = 8'h20; sdata = 8'h00;
        tick();
        for (int i = 1; i <= 2; i++) begin
            n_tests++;
            if (ldr_valid !== (i == 2)) begin
                n_fail++;
                $display("FAIL load_timing cyc+%0d: ldr_valid=%b expected %b", i, ldr_valid, i == 2);
            end
            if (i < 2) tick();
        end
        n_tests++;
        if (ldr_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL load_after_store: got %h expected 5a", ldr_data);
        end
        en_ldr = 1'b0;
        tick(); tick();
    endtask

    task automatic test_priority();
        int drops = 0, lvs = 0, e1s = 0;
        fp = 1'b1; pc = 8'd5; en_ldr = 1'b1; daddr = 8'h20;
        tick();
        fp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drops += int'(req_drop); lvs += int'(ldr_valid); e1s += int'(en1);
            tick();
        end
        n_tests++;
        if (drops != 1 || lvs != 0 || e1s != 1) begin
            n_fail++;
            $display("FAIL fetch_over_load: drops=%0d ldr_valid=%0d en1=%0d expected 1,0,1", drops, lvs, e1s);
        end
        en_ldr = 1'b0;
        tick();
    endtask

    task automatic test_wait_drop();
        int drops = 0, e1s = 0;
        fp = 1'b1; pc = 8'd6;
        tick();
        pc = 8'd5;
        tick();
        fp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drops += int'(req_drop); e1s += int'(en1);
            tick();
        end
        n_tests++;
        if (drops != 1 || e1s != 1) begin
            n_fail++;
            $display("FAIL wait_drop_counts: drops=%0d en1=%0d expected 1,1", drops, e1s);
        end
        n_tests++;
        if (instr !== 16'h1111) begin
            n_fail++;
            $display("FAIL wait_drop_instr: got %h expected 1111", instr);
        end
    endtask

    task automatic test_reset_abort();
        int e1s = 0;
        fp = 1'b1; pc = 8'd5;
        tick();
        fp = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({en1, busy, instr} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_abort_state: en1,busy,instr=%h expected 0", {en1, busy, instr});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            e1s += int'(en1);
        end
        n_tests++;
        if (e1s != 0) begin
            n_fail++;
            $display("FAIL reset_abort_no_en1: en1 pulses=%0d expected 0", e1s);
        end
        fp = 1'b1; pc = 8'd6;
        tick();
        fp = 1'b0;
        tick();
        n_tests++;
        if ({en1, instr} !== {1'b1, 16'h1111}) begin
            n_fail++;
            $display("FAIL fetch_after_reset: en1,instr=%h expected 11111", {en1, instr});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        fp = 1'b1; pc = 8'd5;
        tick();
        fp = 1'b0;
        tick();
        n_tests++;
        if (en1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_resp: en1=%b expected 1", en1);
        end
        fp = 1'b1; pc = 8'd6;
        tick();
        n_tests++;
        if ({req_drop, en1, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_resp_drop: drop,en1,busy=%b expected 100", {req_drop, en1, busy});
        end
        tick();
        fp = 1'b0;
        tick();
        n_tests++;
        if ({en1, instr} !== {1'b1, 16'h1111}) begin
            n_fail++;
            $display("FAIL b2b_second_fetch: en1,instr=%h expected 11111", {en1, instr});
        end
        tick();
        en_str = 1'b1; daddr = 8'h21; sdata = 8'h3C;
        tick();
        n_tests++;
        if ({str_ack, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL store_no_busy: ack,busy=%b expected 10", {str_ack, busy});
        end
        en_ldr = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({ldr_valid, ldr_data, req_drop} !== {1'b1, 8'h3C, 1'b0}) begin
            n_fail++;
            $display("FAIL load_in_ack_cycle: valid,data,drop=%h expected 278", {ldr_valid, ldr_data, req_drop});
        end
        en_ldr = 1'b0; en_str = 1'b0;
        tick();
    endtask

    task automatic test_latency1();
        fp1 = 1'b1; pc1 = 8'd5;
        tick();
        fp1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if ({en1_1, busy_1} !== {i[0], i[0]}) begin
                n_fail++;
                $display("FAIL lat1_timing cyc+%0d: en1,busy=%b expected %b", i, {en1_1, busy_1}, {i[0], i[0]});
            end
            if (i == 1) begin
                n_tests++;
                if (instr_1 !== 16'hA3C1) begin
                    n_fail++;
                    $display("FAIL lat1_instr: got %h expected a3c1", instr_1);
                end
            end
            fp1 = (i == 2);
            tick();
        end
        fp1 = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] m_imem [16];
        logic [7:0]  m_dmem [16];
        logic [15:0] m_val, m_instr;
        logic [7:0]  m_ldata;
        logic [28:0] act, expv;
        int          resp_at, n;
        bit          m_fetch, m_ack, m_drop, prev_l, prev_s, b, r, f, lr, sr;
        bit          ldr_lvl, str_lvl;

        rst = 1'b1; fp = 1'b0; en_ldr = 1'b0; en_str = 1'b0; pwe = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            m_imem[a] = 16'($urandom);
            pwe = 1'b1; paddr = 8'(a); pdata = m_imem[a];
            tick();
        end
        pwe = 1'b0;
        for (int a = 0; a < 16; a++) begin
            m_dmem[a] = 8'($urandom);
            en_str = 1'b1; daddr = 8'(a); sdata = m_dmem[a];
            tick();
            en_str = 1'b0;
            tick();
        end
        resp_at = -1; m_fetch = 1'b0; m_val = '0; m_instr = '0; m_ldata = '0;
        m_ack = 1'b0; m_drop = 1'b0; prev_l = 1'b0; prev_s = 1'b0;
        ldr_lvl = 1'b0; str_lvl = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            b = (c <= resp_at);
            r = (c == resp_at);
            if (r) begin
                if (m_fetch) m_instr = m_val;
                else         m_ldata = m_val[7:0];
            end
            act  = {en1, ldr_valid, str_ack, req_drop, busy, instr, ldr_data};
            expv = {r && m_fetch, r && !m_fetch, m_ack, m_drop, b, m_instr, m_ldata};
            n_tests++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL random cyc %0d: {en1,lv,ack,drop,busy,instr,ldata}=%h expected %h", c, act, expv);
            end
            f = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) ldr_lvl = ~ldr_lvl;
            if ($urandom_range(0, 3) == 0) str_lvl = ~str_lvl;
            fp = f; en_ldr = ldr_lvl; en_str = str_lvl;
            pwe = ($urandom_range(0, 7) == 0);
            pc = 8'($urandom_range(0, 15)); daddr = 8'($urandom_range(0, 15));
            paddr = 8'($urandom_range(0, 15));
            sdata = 8'($urandom); pdata = 16'($urandom);
            lr = ldr_lvl && !prev_l; sr = str_lvl && !prev_s;
            prev_l = ldr_lvl; prev_s = str_lvl;
            m_ack = 1'b0; m_drop = 1'b0;
            if (!b) begin
                n = int'(f) + int'(sr) + int'(lr);
                if (n > 1) m_drop = 1'b1;
                if (f) begin
                    resp_at = c + L; m_fetch = 1'b1; m_val = m_imem[pc[3:0]];
                end else if (sr) begin
                    m_dmem[daddr[3:0]] = sdata; m_ack = 1'b1;
                end else if (lr) begin
                    resp_at = c + L; m_fetch = 1'b0; m_val = {8'h00, m_dmem[daddr[3:0]]};
                end else if (pwe) begin
                    m_imem[paddr[3:0]] = pdata;
                end
                if (pwe && n > 0) m_drop = 1'b1;
            end else if (f || lr || sr || pwe) begin
                m_drop = 1'b1;
            end
            tick();
        end
        fp = 1'b0; pwe = 1'b0; en_ldr = 1'b0; en_str = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fp = 1'b0; en_ldr = 1'b0; en_str = 1'b0; pwe = 1'b0;
        pc = '0; daddr = '0; sdata = '0; paddr = '0; pdata = '0;
        fp1 = 1'b0; pwe1 = 1'b0; pc1 = '0; paddr1 = '0; pdata1 = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_wait_drop();
        test_reset_abort();
        test_back_to_back();
        test_latency1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
